// File: rtl/multicycle_control_pkg.sv
// Shared control-unit definitions: opcodes, ALUOp codes, FSM states and PC source encodings.
// Also used by the ALU control decoder, so the ALUOp constants must stay in step with it.
package uc_defs;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_LDI   = 6'b001111;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [2:0] ALUOP_PASS1 = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_PASS2 = 3'b011;
    localparam logic [2:0] ALUOP_BEQ   = 3'b100;
    localparam logic [2:0] ALUOP_BNE   = 3'b101;

    localparam logic [1:0] PCSRC_SEQ    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic rtype;
        logic load;
        logic store;
        logic branch_eq;
        logic branch_ne;
        logic ldi;
        logic jump;
        logic illegal;
    } insn_class_t;

    // lw/sw are register-indirect, so the address is simply rs passed through.
    function automatic logic [2:0] class_aluop(input insn_class_t c);
        logic [2:0] op;
        op = ALUOP_PASS1;
        if (c.rtype)          op = ALUOP_RTYPE;
        else if (c.ldi)       op = ALUOP_PASS2;
        else if (c.branch_eq) op = ALUOP_BEQ;
        else if (c.branch_ne) op = ALUOP_BNE;
        return op;
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational opcode classifier feeding the multicycle control FSM.
module control_decode
    import uc_defs::*;
#(
    parameter int unsigned OP_W = 6
) (
    input  logic [OP_W-1:0] opcode_i,
    output insn_class_t     cls_o
);

    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OPC_RTYPE: cls_o.rtype     = 1'b1;
            OPC_LW:    cls_o.load      = 1'b1;
            OPC_SW:    cls_o.store     = 1'b1;
            OPC_BEQ:   cls_o.branch_eq = 1'b1;
            OPC_BNE:   cls_o.branch_ne = 1'b1;
            OPC_LDI:   cls_o.ldi       = 1'b1;
            OPC_J:     cls_o.jump      = 1'b1;
            default:   cls_o.illegal   = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: fetch/decode/execute/memory/writeback
// sequencing, variable-latency memory handshake and sticky illegal-opcode halt.
module multicycle_control
    import uc_defs::*;
#(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [OP_W-1:0]    opcode,
    input  logic               alu_flag,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic               iord,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               reg_we,
    output logic               reg_dst,
    output logic               mem_to_reg,
    output logic               illegal,
    output logic               busy
);

    state_t               state_q, state_d;
    insn_class_t          cls;
    logic                 mem_req_q, mem_we_q, iord_q;
    logic                 reg_we_q, reg_dst_q, mem_to_reg_q;
    logic                 illegal_q, busy_q;
    logic [ALUOP_W-1:0]   alu_op_q;
    logic                 is_branch;

    control_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .opcode_i (opcode),
        .cls_o    (cls)
    );

    assign is_branch = cls.branch_eq | cls.branch_ne;

    always_comb begin
        state_d = state_q;
        case (state_q)
            // mem_req_q is low only in the idle cycle after reset; no fetch is outstanding then.
            S_FETCH:  if (mem_req_q && mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                if (cls.illegal)   state_d = S_HALT;
                else if (cls.jump) state_d = S_FETCH;
                else               state_d = S_EXEC;
            end
            S_EXEC: begin
                if (is_branch)                 state_d = S_FETCH;
                else if (cls.load | cls.store) state_d = S_MEM;
                else                           state_d = S_WB;
            end
            S_MEM:    if (mem_ready) state_d = cls.store ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Moore outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= S_FETCH;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            iord_q       <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_dst_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            illegal_q    <= 1'b0;
            busy_q       <= 1'b0;
            alu_op_q     <= ALUOP_PASS1;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= (state_d == S_FETCH) || (state_d == S_MEM);
            iord_q       <= (state_d == S_MEM);
            mem_we_q     <= (state_d == S_MEM) && cls.store;
            reg_we_q     <= (state_d == S_WB);
            reg_dst_q    <= (state_d == S_WB) && cls.rtype;
            mem_to_reg_q <= (state_d == S_WB) && cls.load;
            busy_q       <= 1'b1;
            if (state_q == S_DECODE && state_d == S_EXEC) begin
                alu_op_q <= class_aluop(cls);
            end
            if (state_d == S_HALT) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign ir_we = (state_q == S_FETCH) && mem_req_q && mem_ready;
    assign pc_we = ir_we
                 || ((state_q == S_DECODE) && cls.jump)
                 || ((state_q == S_EXEC) && is_branch && alu_flag);

    always_comb begin
        pc_src = PCSRC_SEQ;
        if (state_q == S_DECODE && cls.jump)     pc_src = PCSRC_JUMP;
        else if (state_q == S_EXEC && is_branch) pc_src = PCSRC_BRANCH;
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign iord       = iord_q;
    assign alu_op     = alu_op_q;
    assign reg_we     = reg_we_q;
    assign reg_dst    = reg_dst_q;
    assign mem_to_reg = mem_to_reg_q;
    assign illegal    = illegal_q;
    assign busy       = busy_q;

endmodule
